// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding (also used by the ALU decoder),
// result-entry flags and the occupancy states of the execute-stage output buffer.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_SLT = 3'b111;

  // Flag half of a result entry; the result word is kept alongside it at the
  // instance's WIDTH so the package stays width-independent.
  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } alu_occ_t;

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of one ALU operation into a result word plus flags.
// Unsupported codes, including any code with X/Z bits, fall to the default arm.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic [WIDTH-1:0] o_result,
  output alu_flags_t       o_flags
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;

  assign w_sum  = i_srca + i_srcb;
  assign w_diff = i_srca - i_srcb;

  assign w_add_ovf = (i_srca[WIDTH-1] == i_srcb[WIDTH-1]) & (w_sum[WIDTH-1]  != i_srca[WIDTH-1]);
  assign w_sub_ovf = (i_srca[WIDTH-1] != i_srcb[WIDTH-1]) & (w_diff[WIDTH-1] != i_srca[WIDTH-1]);

  // Sign of the difference is wrong exactly when the subtraction overflowed.
  assign w_lt = w_diff[WIDTH-1] ^ w_sub_ovf;

  always_comb begin
    w_res   = '0;
    o_flags = '0;
    case (i_op)
      ALU_ADD: begin
        w_res            = w_sum;
        o_flags.overflow = w_add_ovf;
      end
      ALU_SUB: begin
        w_res            = w_diff;
        o_flags.overflow = w_sub_ovf;
      end
      ALU_AND: w_res = i_srca & i_srcb;
      ALU_OR:  w_res = i_srca | i_srcb;
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: o_flags.illegal = 1'b1;
    endcase
    o_flags.zero = (w_res == '0);
  end

  assign o_result = w_res;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready request port, alu_core, and a 2-entry in-order
// output buffer tracked by an occupancy FSM so the consumer can stall.
//
//   state     | meaning
//   OCC_EMPTY | no result held; outputs forced to 0
//   OCC_ONE   | one result in slot 0 (head)
//   OCC_FULL  | slot 0 head, slot 1 next; requests refused
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  alu_occ_t         r_state;
  alu_occ_t         w_state_next;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  alu_flags_t       r_flg0;
  alu_flags_t       r_flg1;
  logic [WIDTH-1:0] w_core_res;
  alu_flags_t       w_core_flg;
  logic             w_push;
  logic             w_pop;
  logic             w_load0;
  logic             w_load0_new;
  logic             w_load1;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (alucontrol),
    .i_srca   (srca),
    .i_srcb   (srcb),
    .o_result (w_core_res),
    .o_flags  (w_core_flg)
  );

  assign in_ready  = (r_state != OCC_FULL);
  assign out_valid = (r_state != OCC_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= OCC_EMPTY;
    else       r_state <= w_state_next;
  end

  // Slot 0 is always the head: it loads a new result or is refilled from slot 1.
  always_comb begin
    w_state_next = r_state;
    w_load0      = 1'b0;
    w_load0_new  = 1'b0;
    w_load1      = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_push) begin
          w_state_next = OCC_ONE;
          w_load0      = 1'b1;
          w_load0_new  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_push && !w_pop) begin
          w_state_next = OCC_FULL;
          w_load1      = 1'b1;
        end else if (w_pop && !w_push) begin
          w_state_next = OCC_EMPTY;
        end else if (w_push && w_pop) begin
          w_load0      = 1'b1;
          w_load0_new  = 1'b1;
        end
      end
      OCC_FULL: begin
        if (w_pop) begin
          w_state_next = OCC_ONE;
          w_load0      = 1'b1;
        end
      end
      default: w_state_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res0 <= '0;
      r_res1 <= '0;
      r_flg0 <= '0;
      r_flg1 <= '0;
    end else begin
      if (w_load0) begin
        r_res0 <= w_load0_new ? w_core_res : r_res1;
        r_flg0 <= w_load0_new ? w_core_flg : r_flg1;
      end
      if (w_load1) begin
        r_res1 <= w_core_res;
        r_flg1 <= w_core_flg;
      end
    end
  end

  assign result   = out_valid ? r_res0 : '0;
  assign zero     = out_valid & r_flg0.zero;
  assign overflow = out_valid & r_flg0.overflow;
  assign illegal  = out_valid & r_flg0.illegal;

endmodule
